// File: rtl/state_dump_if.sv
// Byte stream carrying the dump frame: valid/ready, one byte per accepted cycle.
// No latency of its own; the source holds data and valid until tx_ready accepts.
// The sink may deassert tx_ready for any length of time.
interface state_dump_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/state_dump.sv
// Debug readout: streams header, register file, memory window and XOR checksum as bytes.
// Latency: header one cycle after start; 1 (reg) or 2 (mem) idle cycles between words.
// Backpressure: tx_ready low freezes the byte on tx and suspends all reads.
module state_dump #(
    parameter int NREG      = 32,
    parameter int MEM_WORDS = 32,
    parameter int MEM_BASE  = 0,
    parameter int AW        = 10
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [4:0]    reg_raddr,
    input  logic [31:0]   reg_rdata,
    output logic          mem_ren,
    output logic [AW-1:0] mem_raddr,
    input  logic [31:0]   mem_rdata,
    state_dump_if.master  tx
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HDR      = 3'd1;
    localparam logic [2:0] S_RD_REG   = 3'd2;
    localparam logic [2:0] S_RD_MEM   = 3'd3;
    localparam logic [2:0] S_MEM_WAIT = 3'd4;
    localparam logic [2:0] S_SHIFT    = 3'd5;
    localparam logic [2:0] S_CSUM     = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    // Counter widths leave headroom so NREG=32 and MEM_WORDS=1024 compare cleanly.
    localparam logic [5:0]  NREG_W = 6'(NREG);
    localparam logic [10:0] MEMW   = 11'(MEM_WORDS);

    logic [2:0]  state;
    logic [5:0]  ridx;
    logic [10:0] mcnt;
    logic [1:0]  bcnt;
    logic [31:0] shreg;
    logic [7:0]  csum;
    logic        in_reg;

    assign in_reg    = (ridx < NREG_W);
    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign reg_raddr = ridx[4:0];
    assign mem_ren   = (state == S_RD_MEM);
    assign mem_raddr = mem_ren ? (AW'(MEM_BASE) + AW'(mcnt)) : '0;

    always_comb begin
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;
        case (state)
            S_HDR:   begin tx.tx_valid = 1'b1; tx.tx_data = 8'hA5;         end
            S_SHIFT: begin tx.tx_valid = 1'b1; tx.tx_data = shreg[31:24];  end
            S_CSUM:  begin tx.tx_valid = 1'b1; tx.tx_data = csum;          end
            default: ;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ridx  <= '0;
            mcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
            csum  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state <= S_HDR;
                    ridx  <= '0;
                    mcnt  <= '0;
                    bcnt  <= '0;
                    shreg <= '0;
                    csum  <= '0;
                end
                S_HDR: if (tx.tx_ready) begin
                    if (NREG_W != 6'd0)     state <= S_RD_REG;
                    else if (MEMW != 11'd0) state <= S_RD_MEM;
                    else                    state <= S_CSUM;
                end
                S_RD_REG: begin
                    shreg <= reg_rdata;
                    bcnt  <= '0;
                    state <= S_SHIFT;
                end
                S_RD_MEM: state <= S_MEM_WAIT;
                S_MEM_WAIT: begin
                    shreg <= mem_rdata;
                    bcnt  <= '0;
                    state <= S_SHIFT;
                end
                S_SHIFT: if (tx.tx_ready) begin
                    csum  <= csum ^ shreg[31:24];
                    shreg <= {shreg[23:0], 8'h00};
                    bcnt  <= bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        // Word finished: pick the next source, registers first.
                        if (in_reg) begin
                            ridx <= ridx + 6'd1;
                            if (ridx + 6'd1 < NREG_W) state <= S_RD_REG;
                            else if (MEMW != 11'd0)   state <= S_RD_MEM;
                            else                      state <= S_CSUM;
                        end else begin
                            mcnt <= mcnt + 11'd1;
                            if (mcnt + 11'd1 < MEMW) state <= S_RD_MEM;
                            else                     state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: if (tx.tx_ready) state <= S_DONE;
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_state_dump.sv
// Bench for state_dump: three instances (default, reg-only, wrapping memory window),
// frames predicted from register/memory contents and checked byte by byte by a monitor.
module tb_state_dump;
    logic clk1 = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] st = 3'b000;
    logic rdy = 1'b1;
    int rdy_pct = 100;

    int checks = 0;
    int errors = 0;

    always #5 clk1 = ~clk1;

    logic [31:0] regs [32];
    logic [31:0] mem  [1024];

    state_dump_if ifa();
    state_dump_if ifb();
    state_dump_if ifc();
    assign ifa.tx_ready = rdy;
    assign ifb.tx_ready = rdy;
    assign ifc.tx_ready = rdy;

    logic [2:0]  busy, done, mren;
    logic [4:0]  rra, rrb, rrc;
    logic [9:0]  mra, mrb, mrc;
    logic [31:0] mda, mdb, mdc;

    state_dump dut_a (.clk1(clk1), .rst_n(rst_n), .start(st[0]), .busy(busy[0]), .done(done[0]),
        .reg_raddr(rra), .reg_rdata(regs[rra]), .mem_ren(mren[0]), .mem_raddr(mra),
        .mem_rdata(mda), .tx(ifa.master));

    state_dump #(.NREG(4), .MEM_WORDS(0), .MEM_BASE(7), .AW(10)) dut_b (.clk1(clk1), .rst_n(rst_n),
        .start(st[1]), .busy(busy[1]), .done(done[1]), .reg_raddr(rrb), .reg_rdata(regs[rrb]),
        .mem_ren(mren[1]), .mem_raddr(mrb), .mem_rdata(mdb), .tx(ifb.master));

    state_dump #(.NREG(2), .MEM_WORDS(6), .MEM_BASE(1021), .AW(10)) dut_c (.clk1(clk1), .rst_n(rst_n),
        .start(st[2]), .busy(busy[2]), .done(done[2]), .reg_raddr(rrc), .reg_rdata(regs[rrc]),
        .mem_ren(mren[2]), .mem_raddr(mrc), .mem_rdata(mdc), .tx(ifc.master));

    // Synchronous-read memory model, one read port per instance.
    always @(posedge clk1) begin
        if (mren[0]) mda <= mem[mra];
        if (mren[1]) mdb <= mem[mrb];
        if (mren[2]) mdc <= mem[mrc];
    end

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];
    int         nbytes [3];
    int         done_cnt [3];
    int         mren_seen [3];
    bit         hold [3];
    logic [7:0] hold_dat [3];
    logic [7:0] got [3][300];

    function automatic void push(input int w, input logic [7:0] b);
        case (w)
            0: q0.push_back(b);
            1: q1.push_back(b);
            default: q2.push_back(b);
        endcase
    endfunction

    function automatic bit pop(input int w, output logic [7:0] e);
        e = 8'h00;
        case (w)
            0: if (q0.size() > 0) begin e = q0.pop_front(); return 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); return 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    function automatic int qsize(input int w);
        return (w == 0) ? q0.size() : (w == 1) ? q1.size() : q2.size();
    endfunction

    // Reference frame: header, words big-endian, XOR of payload bytes.
    function automatic void push_frame(input int w, input int nreg, input int nmem, input int base);
        logic [7:0]  cs;
        logic [31:0] word;
        logic [7:0]  b;
        cs = 8'h00;
        push(w, 8'hA5);
        for (int i = 0; i < nreg + nmem; i++) begin
            word = (i < nreg) ? regs[i] : mem[(base + i - nreg) % 1024];
            for (int k = 3; k >= 0; k--) begin
                b = word[8*k +: 8];
                cs = cs ^ b;
                push(w, b);
            end
        end
        push(w, cs);
    endfunction

    task automatic mon(input int w, input logic v, input logic r, input logic [7:0] d);
        logic [7:0] e;
        if (hold[w]) begin
            checks++;
            if (!v || d !== hold_dat[w]) begin
                errors++;
                $display("FAIL hold_%0d valid=%b data=%h required valid=1 data=%h", w, v, d, hold_dat[w]);
            end
        end
        if (v && r) begin
            checks++;
            if (pop(w, e)) begin
                if (d !== e) begin
                    errors++;
                    $display("FAIL byte_%0d[%0d] actual=%h required=%h", w, nbytes[w], d, e);
                end
            end else begin
                errors++;
                $display("FAIL extra_byte_%0d[%0d] actual=%h required=none", w, nbytes[w], d);
            end
            if (nbytes[w] < 300) got[w][nbytes[w]] = d;
            nbytes[w]++;
        end
        hold[w] = v && !r;
        hold_dat[w] = d;
    endtask

    always @(negedge clk1) begin
        if (rst_n) begin
            mon(0, ifa.tx_valid, ifa.tx_ready, ifa.tx_data);
            mon(1, ifb.tx_valid, ifb.tx_ready, ifb.tx_data);
            mon(2, ifc.tx_valid, ifc.tx_ready, ifc.tx_data);
            for (int w = 0; w < 3; w++) begin
                if (done[w]) done_cnt[w]++;
                if (mren[w]) mren_seen[w]++;
            end
        end else begin
            for (int w = 0; w < 3; w++) hold[w] = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk1);
        #1;
        rdy = ($urandom_range(0, 99) < rdy_pct);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic pulse(input int w);
        @(posedge clk1);
        #1 st[w] = 1'b1;
        @(posedge clk1);
        #1 st[w] = 1'b0;
    endtask

    task automatic wait_done(input int w, input int budget);
        int n;
        n = 0;
        while (!done[w] && n < budget) begin
            @(negedge clk1);
            n++;
        end
        checks++;
        if (!done[w]) begin
            errors++;
            $display("FAIL timeout_%0d done=0 required done=1 within %0d cycles", w, budget);
        end
    endtask

    task automatic clear_stats(input int w);
        nbytes[w] = 0;
        done_cnt[w] = 0;
    endtask

    task automatic run(input int w, input int nreg, input int nmem, input int base);
        clear_stats(w);
        push_frame(w, nreg, nmem, base);
        pulse(w);
        wait_done(w, 5000);
        repeat (3) @(negedge clk1);
        chk($sformatf("frame_len_%0d", w), nbytes[w], 2 + 4 * (nreg + nmem));
        chk($sformatf("done_pulses_%0d", w), done_cnt[w], 1);
        chk($sformatf("busy_after_%0d", w), {31'd0, busy[w]}, 0);
        chk($sformatf("leftover_%0d", w), qsize(w), 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i + 3);
        for (int w = 0; w < 3; w++) begin
            clear_stats(w); mren_seen[w] = 0; hold[w] = 1'b0; hold_dat[w] = 8'h00;
        end

        #2;
        chk("rst_busy", {29'd0, busy}, 0);
        chk("rst_done", {29'd0, done}, 0);
        chk("rst_valid", {29'd0, ifc.tx_valid, ifb.tx_valid, ifa.tx_valid}, 0);
        chk("rst_data", {8'd0, ifc.tx_data, ifb.tx_data, ifa.tx_data}, 0);
        chk("rst_mem", {19'd0, mren, mra}, 0);
        chk("rst_raddr", {17'd0, rrc, rrb, rra}, 0);
        repeat (3) @(posedge clk1);
        #1 rst_n = 1'b1;

        // Registers k+3, memory zero, sink always ready.
        rdy_pct = 100;
        run(0, 32, 32, 0);
        chk("first_bytes_0_3", {got[0][0], got[0][1], got[0][2], got[0][3]}, 32'hA5000000);
        chk("first_bytes_4_8", {got[0][4], got[0][5], got[0][6], got[0][7]}, 32'h03000000);
        chk("csum_default", got[0][257], 8'h20);

        mem[0] = 32'h0422_1800;
        run(0, 32, 32, 0);
        chk("mem0_bytes", {got[0][129], got[0][130], got[0][131], got[0][132]}, 32'h0422_1800);
        chk("csum_mem0", got[0][257], 8'h1E);

        // Same data under 30% ready duty.
        rdy_pct = 30;
        run(0, 32, 32, 0);
        chk("csum_slow", got[0][257], 8'h1E);

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        run(0, 32, 32, 0);

        // Start pulsed mid-frame and again in the done cycle: both dropped.
        rdy_pct = 100;
        clear_stats(0);
        push_frame(0, 32, 32, 0);
        pulse(0);
        n = 0;
        while (nbytes[0] < 100 && n < 2000) begin @(negedge clk1); n++; end
        pulse(0);
        n = 0;
        while (!done[0] && n < 5000) begin @(negedge clk1); n++; end
        chk("done_seen", {31'd0, done[0]}, 1);
        st[0] = 1'b1;
        @(posedge clk1);
        #1 st[0] = 1'b0;
        repeat (20) @(negedge clk1);
        chk("ignored_start_len", nbytes[0], 258);
        chk("ignored_start_done", done_cnt[0], 1);
        chk("ignored_start_busy", {31'd0, busy[0]}, 0);
        chk("ignored_start_left", qsize(0), 0);

        // Asynchronous reset mid-frame, then a fresh frame.
        rdy_pct = 60;
        clear_stats(0);
        push_frame(0, 32, 32, 0);
        pulse(0);
        n = 0;
        while (nbytes[0] < 50 && n < 2000) begin @(posedge clk1); n++; end
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, ifa.tx_valid}, 0);
        chk("midrst_busy", {31'd0, busy[0]}, 0);
        chk("midrst_data", {24'd0, ifa.tx_data}, 0);
        chk("midrst_mem", {21'd0, mren[0], mra}, 0);
        chk("midrst_raddr", {27'd0, rra}, 0);
        q0.delete();
        repeat (2) @(posedge clk1);
        #1 rst_n = 1'b1;
        run(0, 32, 32, 0);
        chk("after_rst_hdr", got[0][0], 8'hA5);

        // Register-only instance: 18 bytes, no memory reads.
        rdy_pct = 100;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i + 3);
        run(1, 4, 0, 7);
        chk("regonly_csum", got[1][17], 8'h04);
        chk("regonly_no_mem", mren_seen[1], 0);

        // Memory window wrapping past the top of the address space.
        rdy_pct = 30;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        run(2, 2, 6, 1021);
        chk("wrap_mem_reads", mren_seen[2], 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
